bp_be_prefetch_instr_gen: RTL
=============================

Name: bp_be_prefetch_instr_gen

Overview:
- Consumes loop descriptors from the loop-inference/stride-detection path and generates a bounded burst of software-style prefetch requests toward the scheduler's injection port.
- Each request carries a virtual address one or more strides ahead of the current striding load.
- Acts as the consumer (yumi/ready side) of the loop profiler's valid output and the producer of injected non-speculative prefetch packets.
- The scheduler dispatches these packets as `nspec` memory operations.

Parameters:
- vaddr_width_p, 39, virtual address width.
- stride_width_p, 8, width of signed stride in bytes (two's complement).
- output_range_p, 8, width of remaining-iteration count.
- lookahead_p, 4, maximum prefetches generated per accepted descriptor (must be 1..2^output_range_p-1).
- perf_width_p, 16, width of issued-prefetch performance counter.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- reset_i  in  1  asynchronous, active-low reset (asserted when 0).
- loop_v_i  in  1  loop descriptor valid.
- loop_ready_and_o  out  1  generator can accept descriptor; transfer when loop_v_i & loop_ready_and_o.
- remaining_iterations_i  in  output_range_p  iterations left in detected loop.
- stride_i  in  stride_width_p  signed byte stride of striding load.
- base_vaddr_i  in  vaddr_width_p  current effective address of striding load.
- striding_pc_i  in  vaddr_width_p  PC of striding load.
- flush_i  in  1  pipeline clear/poison; aborts current burst.
- pf_v_o  out  1  prefetch request valid.
- pf_yumi_i  in  1  scheduler consumed request this cycle; legal only when pf_v_o=1.
- pf_vaddr_o  out  vaddr_width_p  prefetch virtual address.
- pf_pc_o  out  vaddr_width_p  PC tag of originating load.
- busy_o  out  1  burst in progress.
- pf_count_o  out  perf_width_p  total prefetches consumed since reset; saturating.

Behaviour:

Reset (reset_i=0, asynchronous):
- state=IDLE; pf_v_o=0, busy_o=0, loop_ready_and_o=1 after release, pf_count_o=0.
- All address, count and PC registers are 0.
- Reset mid-burst drops the burst immediately, with no further pf_v_o.

States: IDLE, GEN.

IDLE:
- loop_ready_and_o=1, pf_v_o=0, busy_o=0.
- On transfer, with stride_sx = sign-extend(stride_i) to vaddr_width_p and n = min(remaining_iterations_i, lookahead_p):
  - n==0 or stride_i==0: descriptor consumed, no prefetch, stay IDLE.
  - Otherwise: addr_r = base_vaddr_i + stride_sx; cnt_r = n; pc_r = striding_pc_i; stride_r = stride_sx; go to GEN.
- flush_i in the same cycle as the transfer has priority: descriptor is consumed and dropped, stay IDLE.

GEN:
- loop_ready_and_o=0, busy_o=1.
- pf_v_o = ~flush_i; pf_vaddr_o=addr_r; pf_pc_o=pc_r.
- Request is registered; first pf_v_o occurs 1 cycle after descriptor transfer.
- On pf_yumi_i & ~flush_i:
  - addr_r += stride_r (modulo 2^vaddr_width_p; wrap is silent).
  - cnt_r -= 1; pf_count_o += 1, saturating at all-ones.
  - If cnt_r==1 before the decrement, go to IDLE; loop_ready_and_o=1 next cycle.
- No pf_yumi_i: hold all outputs stable. pf_v_o must not drop without yumi, except on flush.
- flush_i=1:
  - pf_v_o forced 0 that cycle and pf_yumi_i ignored.
  - Next state IDLE; cnt_r cleared; pf_count_o unchanged.

Invariants:
- Back-to-back yumi sustains 1 request/cycle.
- Maximum burst length is lookahead_p.
- No new descriptor is accepted while busy.
- pf_yumi_i with pf_v_o=0 is a protocol violation; the bench asserts on it.

Test Plan:
- Basic burst: base=0x1000, stride=+8, remaining=10, lookahead 4, yumi every cycle → pf_vaddr 0x1008, 0x1010, 0x1018, 0x1020 on consecutive cycles; busy deasserts after 4th; pf_count=4.
- Short loop and negative stride: remaining=2, stride=-16 (0xF0), base=0x2000 → two requests 0x1FF0, 0x1FE0, then IDLE; remaining=0 or stride=0 → no pf_v_o, ready stays 1.
- Backpressure: yumi withheld 3 cycles on the 2nd request → pf_v_o/pf_vaddr_o stay stable at 0x1010; loop_v_i during GEN not accepted (ready=0).
- Flush mid-burst: flush_i asserted after 1st yumi → pf_v_o=0 same cycle; IDLE and ready=1 next cycle; pf_count=1; flush coincident with descriptor transfer → no prefetch.
- Wrap and saturation: base=2^39-8, stride=+8 → first address 0x0 (wrap), next 0x8; preload counter via 65535 yumis → pf_count stays 0xFFFF.
- Async reset: drop reset_i low mid-GEN between clock edges → pf_v_o=0 and busy_o=0 immediately; after release ready=1 and counter=0.

Source files
------------

// File: rtl/bp_be_prefetch_instr_gen.sv
// bp_be_prefetch_instr_gen: turns accepted loop descriptors into a bounded burst of strided prefetch requests
module bp_be_prefetch_instr_gen #(
    parameter int vaddr_width_p  = 39,
    parameter int stride_width_p = 8,
    parameter int output_range_p = 8,
    parameter int lookahead_p    = 4,
    parameter int perf_width_p   = 16
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      loop_v_i,
    output logic                      loop_ready_and_o,
    input  logic [output_range_p-1:0] remaining_iterations_i,
    input  logic [stride_width_p-1:0] stride_i,
    input  logic [vaddr_width_p-1:0]  base_vaddr_i,
    input  logic [vaddr_width_p-1:0]  striding_pc_i,
    input  logic                      flush_i,
    output logic                      pf_v_o,
    input  logic                      pf_yumi_i,
    output logic [vaddr_width_p-1:0]  pf_vaddr_o,
    output logic [vaddr_width_p-1:0]  pf_pc_o,
    output logic                      busy_o,
    output logic [perf_width_p-1:0]   pf_count_o
);
    typedef enum logic {IDLE, GEN} state_e;

    localparam logic [output_range_p-1:0] la = output_range_p'(lookahead_p);

    state_e                    state_r;
    logic [vaddr_width_p-1:0]  addr_r, pc_r, stride_r, stride_sx;
    logic [output_range_p-1:0] cnt_r, n;
    logic [perf_width_p-1:0]   count_r;

    assign stride_sx        = {{(vaddr_width_p-stride_width_p){stride_i[stride_width_p-1]}}, stride_i};
    assign n                = (remaining_iterations_i < la) ? remaining_iterations_i : la;
    assign loop_ready_and_o = (state_r == IDLE);
    assign busy_o           = (state_r == GEN);
    assign pf_v_o           = busy_o & ~flush_i;
    assign pf_vaddr_o       = addr_r;
    assign pf_pc_o          = pc_r;
    assign pf_count_o       = count_r;

    // Accept a descriptor in IDLE, then walk the stride once per consumed request until the burst is exhausted or flushed
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_r  <= IDLE;
            addr_r   <= '0;
            pc_r     <= '0;
            stride_r <= '0;
            cnt_r    <= '0;
            count_r  <= '0;
        end else if (state_r == IDLE) begin
            if (loop_v_i && !flush_i && n != '0 && stride_i != '0) begin
                addr_r   <= base_vaddr_i + stride_sx;
                cnt_r    <= n;
                pc_r     <= striding_pc_i;
                stride_r <= stride_sx;
                state_r  <= GEN;
            end
        end else if (flush_i) begin
            cnt_r   <= '0;
            state_r <= IDLE;
        end else if (pf_yumi_i) begin
            addr_r <= addr_r + stride_r;
            cnt_r  <= cnt_r - output_range_p'(1);
            if (~&count_r)
                count_r <= count_r + perf_width_p'(1);
            if (cnt_r == output_range_p'(1))
                state_r <= IDLE;
        end
    end
endmodule
